// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game blocks (body, food, render).
// Holds the direction encoding, the body FSM state type and width helpers.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  typedef enum logic {
    ST_ALIVE = 1'b0,
    ST_DEAD  = 1'b1
  } snake_state_t;

  // Coordinate width for a grid dimension of n cells.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Segment count width; one extra bit so MAX_LEN itself is representable.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  // Up<->down and right<->left differ only in the upper encoding bit.
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_seg_buf.sv
// snake_seg_buf: circular buffer of registered (x, y) body segments.
// hd_q indexes the head entry, tl_q the tail entry; valid_q marks live entries.
// Every entry is compared in parallel against the collision probe and the
// render query in the same cycle, which is why the store is flops, not RAM.
module snake_seg_buf
  import snake_pkg::*;
#(
  parameter int H       = 32,
  parameter int V       = 32,
  parameter int MAX_LEN = 64,
  parameter int XW      = 5,
  parameter int YW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [XW-1:0] push_x_i,
  input  logic [YW-1:0] push_y_i,
  input  logic [XW-1:0] cmp_x_i,
  input  logic [YW-1:0] cmp_y_i,
  output logic          cmp_hit_o,
  output logic          cmp_tail_hit_o,
  input  logic [XW-1:0] qry_x_i,
  input  logic [YW-1:0] qry_y_i,
  output logic          qry_hit_o,
  output logic [XW-1:0] head_x_o,
  output logic [YW-1:0] head_y_o,
  output logic [XW-1:0] tail_x_o,
  output logic [YW-1:0] tail_y_o
);

  localparam int PW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  logic [XW-1:0]      x_q [MAX_LEN];
  logic [YW-1:0]      y_q [MAX_LEN];
  logic [MAX_LEN-1:0] valid_q;
  logic [PW-1:0]      hd_q, tl_q;
  logic [PW-1:0]      hd_nxt;
  logic               any_hit, qx_ok, qy_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign hd_nxt = ptr_inc(hd_q);

  // Segment storage: pop is written before push so that, when the buffer is
  // full and the new head lands on the slot being vacated, the push wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      x_q[0]  <= XW'(H / 2 - 2);
      y_q[0]  <= YW'(V / 2);
      x_q[1]  <= XW'(H / 2 - 1);
      y_q[1]  <= YW'(V / 2);
      x_q[2]  <= XW'(H / 2);
      y_q[2]  <= YW'(V / 2);
      valid_q <= MAX_LEN'(7);
      hd_q    <= PW'(2);
      tl_q    <= '0;
    end else begin
      if (pop_i) begin
        valid_q[tl_q] <= 1'b0;
        tl_q          <= ptr_inc(tl_q);
      end
      if (push_i) begin
        x_q[hd_nxt]     <= push_x_i;
        y_q[hd_nxt]     <= push_y_i;
        valid_q[hd_nxt] <= 1'b1;
        hd_q            <= hd_nxt;
      end
    end
  end

  // Parallel compare of every live entry against the probe and the query.
  always_comb begin
    cmp_hit_o = 1'b0;
    any_hit   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (valid_q[i] && (x_q[i] == cmp_x_i) && (y_q[i] == cmp_y_i)) cmp_hit_o = 1'b1;
      if (valid_q[i] && (x_q[i] == qry_x_i) && (y_q[i] == qry_y_i)) any_hit = 1'b1;
    end
  end

  // Out-of-grid queries only exist when a dimension is not a power of two.
  if ((1 << XW) == H) begin : g_qx_full
    assign qx_ok = 1'b1;
  end else begin : g_qx_chk
    assign qx_ok = (qry_x_i < XW'(H));
  end
  if ((1 << YW) == V) begin : g_qy_full
    assign qy_ok = 1'b1;
  end else begin : g_qy_chk
    assign qy_ok = (qry_y_i < YW'(V));
  end

  assign qry_hit_o      = any_hit & qx_ok & qy_ok;
  assign cmp_tail_hit_o = (x_q[tl_q] == cmp_x_i) && (y_q[tl_q] == cmp_y_i);
  assign head_x_o       = x_q[hd_q];
  assign head_y_o       = y_q[hd_q];
  assign tail_x_o       = x_q[tl_q];
  assign tail_y_o       = y_q[tl_q];

endmodule

// File: rtl/snake_body.sv
// snake_body: snake segment store and motion engine.
// Moves one cell every TICK cycles, grows on point, answers render queries
// with one cycle latency and raises a sticky dead flag on collision.
// Build option: define SNAKE_WRAP_EN to make the head wrap at grid edges
// instead of dying on the wall.
module snake_body
  import snake_pkg::*;
#(
  parameter int H       = 32,
  parameter int V       = 32,
  parameter int MAX_LEN = 64,
  parameter int TICK    = 4_000_000,
  localparam int XW     = coord_w(H),
  localparam int YW     = coord_w(V),
  localparam int LW     = len_w(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    dir_req,
  input  logic          point,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y,
  output logic          shift,
  output logic [LW-1:0] length,
  output logic          dead
);

  localparam int CW = (TICK > 2) ? $clog2(TICK) : 1;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  snake_state_t  state_q;
  dir_t          cur_dir_q, next_dir_q, ref_dir;
  logic [CW-1:0] cnt_q;
  logic          grow_pending_q, shift_q, query_hit_q;
  logic [LW-1:0] length_q;

  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic          at_wall, move, grow, collide, push, pop;
  logic          cmp_hit, cmp_tail_hit, qry_hit;

  assign move    = (state_q == ST_ALIVE) && (cnt_q == CW'(TICK - 1));
  assign grow    = (grow_pending_q | point) && (length_q < LW'(MAX_LEN));
  // The tail may be re-entered only when it vacates in this same move.
  assign collide = (at_wall & ~WRAP) | (cmp_hit & ~(cmp_tail_hit & ~grow));
  assign push    = move & ~collide;
  assign pop     = push & ~grow;
  // On the move edge next_dir becomes current, so reversal is judged against it.
  assign ref_dir = move ? next_dir_q : cur_dir_q;

  // Next head cell one step in next_dir, with wrap value and wall flag.
  always_comb begin
    new_x   = head_x;
    new_y   = head_y;
    at_wall = 1'b0;
    case (next_dir_q)
      DIR_UP: begin
        if (head_y == '0) begin
          new_y   = YW'(V - 1);
          at_wall = 1'b1;
        end else new_y = head_y - 1'b1;
      end
      DIR_RIGHT: begin
        if (head_x == XW'(H - 1)) begin
          new_x   = '0;
          at_wall = 1'b1;
        end else new_x = head_x + 1'b1;
      end
      DIR_DOWN: begin
        if (head_y == YW'(V - 1)) begin
          new_y   = '0;
          at_wall = 1'b1;
        end else new_y = head_y + 1'b1;
      end
      default: begin
        if (head_x == '0) begin
          new_x   = XW'(H - 1);
          at_wall = 1'b1;
        end else new_x = head_x - 1'b1;
      end
    endcase
  end

  // Alive/dead FSM with direction latch, move timer, growth and query register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_ALIVE;
      cur_dir_q      <= DIR_RIGHT;
      next_dir_q     <= DIR_RIGHT;
      cnt_q          <= '0;
      grow_pending_q <= 1'b0;
      shift_q        <= 1'b0;
      length_q       <= LW'(3);
      query_hit_q    <= 1'b0;
    end else begin
      query_hit_q <= qry_hit;
      shift_q     <= 1'b0;
      if (state_q == ST_ALIVE) begin
        if (dir_req != dir_opposite(ref_dir)) next_dir_q <= dir_req;
        cnt_q <= move ? '0 : cnt_q + 1'b1;
        if (move) begin
          grow_pending_q <= 1'b0;
          if (collide) begin
            state_q <= ST_DEAD;
          end else begin
            cur_dir_q <= next_dir_q;
            shift_q   <= 1'b1;
            if (grow) length_q <= length_q + 1'b1;
          end
        end else if (point) begin
          grow_pending_q <= 1'b1;
        end
      end
    end
  end

  snake_seg_buf #(
    .H(H), .V(V), .MAX_LEN(MAX_LEN), .XW(XW), .YW(YW)
  ) u_seg_buf (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .pop_i         (pop),
    .push_x_i      (new_x),
    .push_y_i      (new_y),
    .cmp_x_i       (new_x),
    .cmp_y_i       (new_y),
    .cmp_hit_o     (cmp_hit),
    .cmp_tail_hit_o(cmp_tail_hit),
    .qry_x_i       (query_x),
    .qry_y_i       (query_y),
    .qry_hit_o     (qry_hit),
    .head_x_o      (head_x),
    .head_y_o      (head_y),
    .tail_x_o      (tail_x),
    .tail_y_o      (tail_y)
  );

  assign query_hit = query_hit_q;
  assign shift     = shift_q;
  assign length    = length_q;
  assign dead      = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed, table-driven bench for snake_body (TICK=4, MAX_LEN=8).
// Honours SNAKE_WRAP_EN for the wall sequences.
module tb_snake_body;
  import snake_pkg::*;

  localparam int H = 32, V = 32, MAX_LEN = 8, TICK = 4;
  localparam int XW = 5, YW = 5, LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    dir_req = DIR_RIGHT;
  logic          point = 1'b0;
  logic [XW-1:0] query_x = '0;
  logic [YW-1:0] query_y = '0;
  logic          query_hit;
  logic [XW-1:0] head_x, tail_x;
  logic [YW-1:0] head_y, tail_y;
  logic          shift, dead;
  logic [LW-1:0] length;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] dir;
    int         pts;
    int         hx, hy, tx, ty, len;
    bit         dead;
  } row_t;

  row_t seq_a [9];
  row_t seq_b [6];

  // clock / reset block
  always #5 clk = ~clk;

  snake_body #(.H(H), .V(V), .MAX_LEN(MAX_LEN), .TICK(TICK)) dut (
    .clk      (clk),
    .reset    (reset),
    .dir_req  (dir_req),
    .point    (point),
    .query_x  (query_x),
    .query_y  (query_y),
    .query_hit(query_hit),
    .head_x   (head_x),
    .head_y   (head_y),
    .tail_x   (tail_x),
    .tail_y   (tail_y),
    .shift    (shift),
    .length   (length),
    .dead     (dead)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int hx, input int hy, input int tx,
                           input int ty, input int len, input bit dd, input bit sh);
    chk({tag, " head_x"}, 32'(head_x), hx);
    chk({tag, " head_y"}, 32'(head_y), hy);
    chk({tag, " tail_x"}, 32'(tail_x), tx);
    chk({tag, " tail_y"}, 32'(tail_y), ty);
    chk({tag, " length"}, 32'(length), len);
    chk({tag, " dead"},   32'(dead),   32'(dd));
    chk({tag, " shift"},  32'(shift),  32'(sh));
  endtask

  // Leaves the bench in the first cycle after reset (counter = 0).
  task automatic do_reset(input string tag);
    reset   = 1'b1;
    point   = 1'b0;
    dir_req = DIR_RIGHT;
    step(2);
    reset = 1'b0;
    chk_state({tag, " reset"}, 16, 16, 14, 16, 3, 1'b0, 1'b0);
    chk({tag, " reset query_hit"}, 32'(query_hit), 0);
  endtask

  // One move period: optional point pulses in cycles 0 and 2, then compare.
  task automatic run_row(input string tag, input row_t r);
    dir_req = r.dir;
    point = (r.pts >= 1);
    step(1);
    point = 1'b0;
    step(1);
    point = (r.pts >= 2);
    step(1);
    point = 1'b0;
    step(1);
    chk_state(tag, r.hx, r.hy, r.tx, r.ty, r.len, r.dead, !r.dead);
  endtask

  initial begin
    logic [XW-1:0] qx [3];
    logic [YW-1:0] qy [3];
    logic          qe [3];

    // grow, collapse double point, ignore reversal, turn, die into own body
    seq_a[0] = '{DIR_RIGHT, 0, 17, 16, 15, 16, 3, 1'b0};
    seq_a[1] = '{DIR_RIGHT, 1, 18, 16, 15, 16, 4, 1'b0};
    seq_a[2] = '{DIR_RIGHT, 0, 19, 16, 16, 16, 4, 1'b0};
    seq_a[3] = '{DIR_LEFT,  0, 20, 16, 17, 16, 4, 1'b0};
    seq_a[4] = '{DIR_UP,    0, 20, 15, 18, 16, 4, 1'b0};
    seq_a[5] = '{DIR_UP,    2, 20, 14, 18, 16, 5, 1'b0};
    seq_a[6] = '{DIR_RIGHT, 0, 21, 14, 19, 16, 5, 1'b0};
    seq_a[7] = '{DIR_DOWN,  0, 21, 15, 20, 16, 5, 1'b0};
    seq_a[8] = '{DIR_LEFT,  0, 21, 15, 20, 16, 5, 1'b1};
    // length-4 square loop into the vacating tail, then same with growth
    seq_b[0] = '{DIR_RIGHT, 1, 17, 16, 14, 16, 4, 1'b0};
    seq_b[1] = '{DIR_DOWN,  0, 17, 17, 15, 16, 4, 1'b0};
    seq_b[2] = '{DIR_LEFT,  0, 16, 17, 16, 16, 4, 1'b0};
    seq_b[3] = '{DIR_UP,    0, 16, 16, 17, 16, 4, 1'b0};
    seq_b[4] = '{DIR_RIGHT, 0, 17, 16, 17, 17, 4, 1'b0};
    seq_b[5] = '{DIR_DOWN,  1, 17, 16, 17, 17, 4, 1'b1};

    // query streaming right after reset, one cycle latency
    do_reset("q");
    qx[0] = 5'd15; qy[0] = 5'd16; qe[0] = 1'b1;
    qx[1] = 5'd16; qy[1] = 5'd16; qe[1] = 1'b1;
    qx[2] = 5'd0;  qy[2] = 5'd0;  qe[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      query_x = qx[i];
      query_y = qy[i];
      #1;
      if (i > 0) chk($sformatf("query %0d held", i - 1), 32'(query_hit), 32'(qe[i - 1]));
      @(posedge clk);
      #1;
      chk($sformatf("query %0d", i), 32'(query_hit), 32'(qe[i]));
    end

    do_reset("a");
    for (int i = 0; i < 9; i++) run_row($sformatf("a%0d", i), seq_a[i]);
    step(8);
    chk_state("a dead hold", 21, 15, 20, 16, 5, 1'b1, 1'b0);

    do_reset("b");
    for (int i = 0; i < 6; i++) run_row($sformatf("b%0d", i), seq_b[i]);

    // right wall
    do_reset("wr");
    step(4 * 15);
    chk_state("wr edge", 31, 16, 29, 16, 3, 1'b0, 1'b1);
    step(4);
`ifdef SNAKE_WRAP_EN
    chk_state("wr wrap", 0, 16, 30, 16, 3, 1'b0, 1'b1);
`else
    chk_state("wr die", 31, 16, 29, 16, 3, 1'b1, 1'b0);
    step(5);
    chk_state("wr hold", 31, 16, 29, 16, 3, 1'b1, 1'b0);
`endif

    // top wall
    do_reset("wu");
    dir_req = DIR_UP;
    step(4 * 16);
    chk_state("wu edge", 16, 0, 16, 2, 3, 1'b0, 1'b1);
    step(4);
`ifdef SNAKE_WRAP_EN
    chk_state("wu wrap", 16, 31, 16, 1, 3, 1'b0, 1'b1);
`else
    chk_state("wu die", 16, 0, 16, 2, 3, 1'b1, 1'b0);
`endif

    // point in the move cycle itself, saturation at MAX_LEN, full-buffer wrap
    do_reset("s");
    step(3);
    point = 1'b1;
    step(1);
    point = 1'b0;
    chk_state("s1", 17, 16, 14, 16, 4, 1'b0, 1'b1);
    for (int k = 2; k <= 6; k++) begin
      point = 1'b1;
      step(1);
      point = 1'b0;
      step(3);
      chk_state($sformatf("s%0d", k), 16 + k, 16, (k == 6) ? 15 : 14, 16,
                (3 + k > MAX_LEN) ? MAX_LEN : 3 + k, 1'b0, 1'b1);
    end
    query_x = 5'd22; query_y = 5'd16;
    step(1);
    chk("s query head", 32'(query_hit), 1);
    query_x = 5'd14; query_y = 5'd16;
    step(1);
    chk("s query popped", 32'(query_hit), 0);
    step(2);
    chk_state("s7", 23, 16, 16, 16, 8, 1'b0, 1'b1);

    // reset coinciding with a move and a point
    step(3);
    reset = 1'b1;
    point = 1'b1;
    step(1);
    reset = 1'b0;
    point = 1'b0;
    chk_state("rst override", 16, 16, 14, 16, 3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_body.md
# snake_body

Segment store and motion engine for the snake game. Holds the snake's body as a circular buffer of grid coordinates, advances it one cell per move period in the latched direction, and grows by one segment for each `point` pulse from the food logic. Publishes head/tail coordinates and a one-cycle `shift` pulse to the food logic. Answers per-pixel occupancy queries for the renderer, and flags death on wall or self collision.

## Interface
- `H`, 32: grid width in cells.
- `V`, 32: grid height in cells.
- `MAX_LEN`, 64: maximum segment count, at least 4.
- `TICK`, 4_000_000: clock cycles per move period, at least 2.

Coordinate width is XW = clog2(H) and YW = clog2(V). Length width is LW = clog2(MAX_LEN)+1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `dir_req` in 2: requested direction (00 up, 01 right, 10 down, 11 left). Sampled every cycle.
- `point` in 1: one-cycle pulse requesting growth.
- `query_x` in XW: renderer query column.
- `query_y` in YW: renderer query row.
- `query_hit` out 1: registered; 1 if (query_x, query_y) holds any segment.
- `head_x` out XW, `head_y` out YW: head cell.
- `tail_x` out XW, `tail_y` out YW: last segment cell.
- `shift` out 1: one-cycle pulse; the snake moved.
- `length` out LW: current segment count.
- `dead` out 1: sticky collision flag.

## Operation
**Reset values**
- Head at (H/2, V/2). Body at (H/2-1, V/2) and (H/2-2, V/2). Tail = (H/2-2, V/2). `length` = 3.
- Current direction = right.
- `shift` = 0, `dead` = 0, `query_hit` = 0.
- `grow_pending` = 0. Tick counter = 0.

**Direction latch**
- On every cycle, `dir_req` is copied into `next_dir` unless it is the exact opposite of the current direction. Opposite requests are ignored.
- `next_dir` becomes the current direction at the move edge.

**Tick counter**
- Counts 0 to TICK-1 while `dead` = 0, then wraps to 0.
- The cycle in which the count equals TICK-1 is the move cycle.

**Move cycle**
- The new head is the old head plus one cell in `next_dir`. Up decrements y.
- grow = `grow_pending` OR `point`, and `length` < MAX_LEN.
- If grow: the new head is pushed and `length` increments; the tail is unchanged.
- If not grow: the new head is pushed and the oldest segment is popped; the tail moves.
- `grow_pending` clears on every move, including when growth was suppressed because `length` = MAX_LEN.

**Point outside a move cycle**
- `point` sets `grow_pending`.
- Multiple points between two moves collapse into one growth.

**Wall collision**
- Applies only without `SNAKE_WRAP_EN`.
- A new head outside 0..H-1 or 0..V-1 sets `dead`. No push occurs and `shift` stays 0.

**Self collision**
- A new head equal to any current segment sets `dead`, with no push and no `shift`.
- The one exception is the tail segment when not growing: the tail vacates in the same move, so the new head may occupy it.

**Dead state**
- Counter frozen. No further moves. All outputs hold.
- Left only by `reset`.

**Query**
- `query_hit` reflects segment state before any push in the same cycle.
- Out-of-range query coordinates return 0.

## Timing
- Move cycle at edge k: `head_*`, `tail_*` and `length` update at edge k, and `shift` = 1 for exactly the cycle after edge k.
- `dead` rises at edge k with `shift` = 0.
- `query_hit` latency is one cycle: query presented in cycle n, result valid in cycle n+1. Continuous streaming at one query per cycle.
- `dir_req` must be stable in the move cycle to take effect on that move.
- `reset` asserted mid-operation overrides everything in the same edge, including a coincident move or `point`.

## Configuration
- `SNAKE_WRAP_EN` defined: the head wraps at grid edges. x = H-1 moving right becomes 0, y = 0 moving up becomes V-1, and so on. Walls never kill.
- Not defined: leaving the grid sets `dead` as described under Operation.
- Self collision applies in both builds.

## Structure
Shared package `snake_pkg` holds:
- Direction encoding constants `DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`.
- A `dir_t` typedef.
- `clog2`-based width helpers for XW, YW and LW.

It is also used by the food and render blocks.

Sub-module `snake_seg_buf`:
- Circular buffer of MAX_LEN registered (x, y) entries with head/tail pointers, plus a valid mask.
- push/pop ports.
- Parallel compare ports for the collision check and the render query.
- Registers are required because every compare runs against all entries in the same cycle; a RAM cannot serve that.

## Test plan
1. Reset, TICK=4 → head (16,16), tail (14,16), `length` 3. First `shift` after 4 cycles with head (17,16) and tail (15,16).
2. Pulse `point` mid-period → the next move gives `length` 4, tail stays (15,16). The following move advances the tail normally.
3. `dir_req` = left while moving right → ignored, head keeps incrementing x. `dir_req` = up → next move gives head y = 15.
4. Drive right until x = 31, then one more move → without `SNAKE_WRAP_EN`: `dead` = 1, no `shift`, head stays (31,16). With it: head (0,16).
5. Grow to `length` 5, then turn up, left, down in successive moves → the head re-enters its own body and `dead` = 1. At `length` 4 the same loop into the vacating tail does not die.
6. Query (15,16), (16,16), (0,0) on consecutive cycles after reset → `query_hit` reads 1, 1, 0, each one cycle late.
